// File: rtl/wb_stage.sv
// Writeback stage: merges ALU results with loads buffered in a 2-entry FIFO into one
// register-file write port and tracks which registers are waiting on a load.
module wb_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [3:0]  alu_rd,
  input  logic [15:0] alu_data,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [3:0]  mem_rd,
  input  logic [15:0] mem_data,
  input  logic        load_issue,
  input  logic [3:0]  load_issue_rd,
  output logic        reg_write,
  output logic [3:0]  rd,
  output logic [15:0] rd_data,
  output logic [15:0] busy
);

  localparam int unsigned Depth = 2;

  typedef struct packed {
    logic [3:0]  rd;
    logic [15:0] data;
  } entry_t;

  entry_t      fifo_q [Depth];
  logic        wr_ptr_q;
  logic        rd_ptr_q;
  logic [1:0]  count_q;
  logic [1:0]  count_d;
  logic [15:0] busy_q;
  logic [15:0] busy_d;
  logic [15:0] busy_set;
  logic [15:0] busy_clr;

  logic   full;
  logic   push;
  logic   pop;
  logic   take_alu;
  logic   sel_valid;
  entry_t head;
  entry_t sel;

  always_comb begin
    full      = (count_q == 2'd2);
    mem_ready = !full;
    alu_ready = !full;
    push      = mem_valid && mem_ready;
    // A full buffer always drains first; otherwise the ALU has priority over the buffer.
    pop       = full || (!alu_valid && (count_q != 2'd0));
    take_alu  = alu_valid && !full;
    head      = fifo_q[rd_ptr_q];
    sel_valid = pop || take_alu;
    sel       = pop ? head : entry_t'{rd: alu_rd, data: alu_data};
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Set is applied after clear so a same-edge reissue keeps the bit pending.
  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    if (load_issue) busy_set[load_issue_rd] = 1'b1;
    if (pop)        busy_clr[head.rd]       = 1'b1;
    busy_d    = (busy_q & ~busy_clr) | busy_set;
    busy_d[0] = 1'b0;
  end

  assign busy = busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= 2'd0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      reg_write <= 1'b0;
      rd        <= 4'd0;
      rd_data   <= 16'd0;
      busy_q    <= 16'd0;
    end else begin
      count_q <= count_d;
      busy_q  <= busy_d;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      reg_write <= sel_valid && (sel.rd != 4'd0);
      if (sel_valid) begin
        rd      <= sel.rd;
        rd_data <= sel.data;
      end
    end
  end

  // Storage needs no reset: count and pointers define which slots are live.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= entry_t'{rd: mem_rd, data: mem_data};
  end

  assert property (@(posedge clk) disable iff (rst) count_q <= 2'd2);
  assert property (@(posedge clk) disable iff (rst) busy_q[0] == 1'b0);

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: stimulus queues expected writes, a negedge monitor
// matches every reg_write pulse against the queue in order.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic        alu_ready;
  logic [3:0]  alu_rd;
  logic [15:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [3:0]  mem_rd;
  logic [15:0] mem_data;
  logic        load_issue;
  logic [3:0]  load_issue_rd;
  logic        reg_write;
  logic [3:0]  rd;
  logic [15:0] rd_data;
  logic [15:0] busy;

  int n_checks = 0;
  int n_errors = 0;
  logic [19:0] exp_q [$];

  wb_stage dut (
    .clk           (clk),
    .rst           (rst),
    .alu_valid     (alu_valid),
    .alu_ready     (alu_ready),
    .alu_rd        (alu_rd),
    .alu_data      (alu_data),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready),
    .mem_rd        (mem_rd),
    .mem_data      (mem_data),
    .load_issue    (load_issue),
    .load_issue_rd (load_issue_rd),
    .reg_write     (reg_write),
    .rd            (rd),
    .rd_data       (rd_data),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [3:0] r, input logic [15:0] d);
    exp_q.push_back({r, d});
  endtask

  task automatic cyc(input logic av, input logic [3:0] ar, input logic [15:0] ad,
                     input logic mv, input logic [3:0] mr, input logic [15:0] md,
                     input logic li, input logic [3:0] lr);
    alu_valid     = av;
    alu_rd        = ar;
    alu_data      = ad;
    mem_valid     = mv;
    mem_rd        = mr;
    mem_data      = md;
    load_issue    = li;
    load_issue_rd = lr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0);
  endtask

  // Monitor: every write pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && reg_write) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: got rd=%0d data=0x%0h expected no write", rd, rd_data);
      end else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        check("wr_rd", int'(rd), int'(e[19:16]));
        check("wr_data", int'(rd_data), int'(e[15:0]));
      end
    end
  end

  initial begin
    rst = 1'b1;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    mem_valid = 0; mem_rd = 0; mem_data = 0;
    load_issue = 0; load_issue_rd = 0;
    #1;
    check("rst_reg_write", int'(reg_write), 0);
    check("rst_rd", int'(rd), 0);
    check("rst_rd_data", int'(rd_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_mem_ready", int'(mem_ready), 1);
    check("rst_alu_ready", int'(alu_ready), 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // ALU only: one-cycle latency, then hold on idle
    expect_wr(4'd3, 16'h1234);
    cyc(1'b1, 4'd3, 16'h1234, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0);
    check("alu_reg_write", int'(reg_write), 1);
    idle();
    check("idle_reg_write", int'(reg_write), 0);
    check("idle_rd_hold", int'(rd), 3);
    check("idle_data_hold", int'(rd_data), 16'h1234);

    // Load latency and busy tracking
    cyc(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 1'b1, 4'd5);
    check("busy_set5", int'(busy), 16'h0020);
    expect_wr(4'd5, 16'hBEEF);
    cyc(1'b0, 4'd0, 16'd0, 1'b1, 4'd5, 16'hBEEF, 1'b0, 4'd0);
    check("load_not_yet", int'(reg_write), 0);
    check("busy5_pending", int'(busy), 16'h0020);
    idle();
    check("load_written", int'(reg_write), 1);
    check("busy5_clear", int'(busy), 0);

    // Full buffer: head wins over ALU, ALU written afterwards
    cyc(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 1'b1, 4'd1);
    cyc(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 1'b1, 4'd2);
    check("busy_1_2", int'(busy), 16'h0006);
    expect_wr(4'd4, 16'h0A0A);
    cyc(1'b1, 4'd4, 16'h0A0A, 1'b1, 4'd1, 16'h1111, 1'b0, 4'd0);
    expect_wr(4'd4, 16'h0B0B);
    cyc(1'b1, 4'd4, 16'h0B0B, 1'b1, 4'd2, 16'h2222, 1'b0, 4'd0);
    check("full_mem_ready", int'(mem_ready), 0);
    check("full_alu_ready", int'(alu_ready), 0);
    expect_wr(4'd1, 16'h1111);
    cyc(1'b1, 4'd6, 16'h0C0C, 1'b1, 4'd9, 16'h9999, 1'b0, 4'd0);
    check("drain_mem_ready", int'(mem_ready), 1);
    check("busy_2_only", int'(busy), 16'h0004);
    expect_wr(4'd6, 16'h0C0C);
    cyc(1'b1, 4'd6, 16'h0C0C, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0);
    expect_wr(4'd2, 16'h2222);
    idle();
    check("busy_drained", int'(busy), 0);
    idle();
    check("empty_reg_write", int'(reg_write), 0);

    // Destination 0 never writes and never marks busy
    cyc(1'b1, 4'd0, 16'hFFFF, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0);
    check("rd0_alu_no_write", int'(reg_write), 0);
    cyc(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 1'b1, 4'd0);
    check("rd0_busy", int'(busy), 0);
    cyc(1'b0, 4'd0, 16'd0, 1'b1, 4'd0, 16'h1357, 1'b0, 4'd0);
    idle();
    check("rd0_load_no_write", int'(reg_write), 0);

    // Same-edge clear and set of busy[7]
    cyc(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 1'b1, 4'd7);
    cyc(1'b0, 4'd0, 16'd0, 1'b1, 4'd7, 16'h7777, 1'b0, 4'd0);
    expect_wr(4'd7, 16'h7777);
    cyc(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 1'b1, 4'd7);
    check("busy7_kept", int'(busy), 16'h0080);
    cyc(1'b0, 4'd0, 16'd0, 1'b1, 4'd7, 16'h8888, 1'b0, 4'd0);
    expect_wr(4'd7, 16'h8888);
    idle();
    check("busy7_clear", int'(busy), 0);

    // Reset with two loads buffered discards them
    cyc(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 1'b1, 4'd3);
    expect_wr(4'd8, 16'h0808);
    cyc(1'b1, 4'd8, 16'h0808, 1'b1, 4'd3, 16'h3333, 1'b0, 4'd0);
    cyc(1'b1, 4'd0, 16'hABCD, 1'b1, 4'd3, 16'h4444, 1'b0, 4'd0);
    check("pre_rst_full", int'(mem_ready), 0);
    check("pre_rst_data", int'(rd_data), 16'hABCD);
    check("pre_rst_busy", int'(busy), 16'h0008);
    alu_valid = 0;
    mem_valid = 0;
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_reg_write", int'(reg_write), 0);
    check("mid_rst_rd_data", int'(rd_data), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_mem_ready", int'(mem_ready), 1);
    check("mid_rst_alu_ready", int'(alu_ready), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle();
      check("post_rst_no_write", int'(reg_write), 0);
    end
    check("post_rst_mem_ready", int'(mem_ready), 1);

    repeat (2) @(posedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
